// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobe, frame debounce,
// single-key press/release events through a valid/ready register.
module keypad_scanner #(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int SCAN_CYCLES = 16,
   parameter int DEBOUNCE    = 4,
   parameter int CODE_W      = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   row,
   output logic [COLS-1:0]   col,
   output logic [CODE_W-1:0] key_code,
   output logic              key_release,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              pressed,
   output logic              multi,
   output logic              overrun
);

   localparam int N  = ROWS*COLS;
   localparam int DW = $clog2(SCAN_CYCLES);
   localparam int CW = $clog2(COLS);
   localparam logic [DW-1:0] DLAST = DW'(SCAN_CYCLES-1);
   localparam logic [CW-1:0] CLAST = CW'(COLS-1);
   localparam logic [3:0]    DBC   = 4'(DEBOUNCE);

   logic [ROWS-1:0] row_s1, row_s2;
   logic [DW-1:0]   dwell;
   logic [CW-1:0]   cidx;
   logic [N-1:0]    frame, frame_nxt, prev, deb, old;
   logic [3:0]      cnt, cnt_nxt;
   logic            load_pend, load_now, chg, lockout, lock_nxt;
   logic            dwell_end, frame_end, differs;
   logic            ev, ev_rel;
   logic [CODE_W-1:0] ev_code;
   logic [6:0]      n_new, n_old;

   function automatic logic [6:0] popc(input logic [N-1:0] v);
      popc = '0;
      for (int i = 0; i < N; i++) popc += 7'(v[i]);
   endfunction

   function automatic logic [CODE_W-1:0] idx(input logic [N-1:0] v);
      idx = '0;
      for (int i = 0; i < N; i++) if (v[i]) idx = CODE_W'(i);
   endfunction

   assign dwell_end = (dwell == DLAST);
   assign frame_end = dwell_end && (cidx == CLAST);
   assign col       = {{(COLS-1){1'b0}}, 1'b1} << cidx;
   assign differs   = (frame_nxt != prev);
   assign n_new     = popc(deb);
   assign n_old     = popc(old);

   // Frame with the current column's synchronised rows merged in
   always_comb begin
      frame_nxt = frame;
      frame_nxt[int'(cidx)*ROWS +: ROWS] = row_s2;
   end

   // Stability count and the "reaches DEBOUNCE" load condition
   always_comb begin
      cnt_nxt  = cnt;
      load_now = 1'b0;
      if (differs) begin
         cnt_nxt  = 4'd1;
         load_now = (DEBOUNCE == 1);
      end else begin
         cnt_nxt  = (cnt == DBC) ? cnt : cnt + 4'd1;
         load_now = (cnt == DBC - 4'd1);
      end
   end

   // Event decision on a debounced-matrix change, with multi-key lockout
   always_comb begin
      ev       = 1'b0;
      ev_rel   = 1'b0;
      ev_code  = '0;
      lock_nxt = lockout;
      if (chg) begin
         if (lockout) begin
            if (n_new == 7'd0) lock_nxt = 1'b0;
         end else if (n_new >= 7'd2) begin
            lock_nxt = 1'b1;
         end else if (n_new == 7'd1) begin
            ev      = 1'b1;
            ev_code = idx(deb);
         end else if (n_old == 7'd1) begin
            ev      = 1'b1;
            ev_rel  = 1'b1;
            ev_code = idx(old);
         end
      end
   end

   // Row synchroniser, scan counters and frame capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1    <= '0;
         row_s2    <= '0;
         dwell     <= '0;
         cidx      <= '0;
         frame     <= '0;
         prev      <= '0;
         cnt       <= '0;
         load_pend <= 1'b0;
      end else begin
         row_s1    <= row;
         row_s2    <= row_s1;
         load_pend <= frame_end && load_now;
         if (dwell_end) begin
            dwell <= '0;
            cidx  <= (cidx == CLAST) ? '0 : cidx + CW'(1);
            frame <= frame_nxt;
         end else begin
            dwell <= dwell + DW'(1);
         end
         if (frame_end) begin
            prev <= frame_nxt;
            cnt  <= cnt_nxt;
         end
      end
   end

   // Debounced matrix, keeping the previous one for event decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb <= '0;
         old <= '0;
         chg <= 1'b0;
      end else begin
         chg <= 1'b0;
         if (load_pend) begin
            deb <= prev;
            old <= deb;
            chg <= (prev != deb);
         end
      end
   end

   // Status flags, lockout and the single-entry event register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pressed     <= 1'b0;
         multi       <= 1'b0;
         lockout     <= 1'b0;
         key_code    <= '0;
         key_release <= 1'b0;
         key_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         pressed <= (n_new != 7'd0);
         multi   <= (n_new >= 7'd2);
         lockout <= lock_nxt;
         if (ev) begin
            if (!key_valid || key_ready) begin
               key_code    <= ev_code;
               key_release <= ev_rel;
               key_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: directed key matrices,
// expected events queued and checked by a separate monitor.
module tb_keypad_scanner;

   localparam int R = 4;
   localparam int C = 4;
   localparam int S = 8;
   localparam int D = 3;
   localparam int F = C*S;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_release, key_valid, key_ready;
   logic       pressed, multi, overrun;
   logic [15:0] keys = '0;
   logic       bounce = 1'b0;

   typedef struct {
      logic [3:0] code;
      logic       rel;
      logic       chkp;
      logic       p;
   } ev_t;

   ev_t q[$];
   int  n_chk = 0;
   int  n_fail = 0;

   keypad_scanner #(.ROWS(R), .COLS(C), .SCAN_CYCLES(S), .DEBOUNCE(D)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .key_code(key_code), .key_release(key_release),
      .key_valid(key_valid), .key_ready(key_ready),
      .pressed(pressed), .multi(multi), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Physical matrix: a pressed key shorts its column strobe onto its row
   always_comb begin
      row = {3'b000, bounce};
      for (int c = 0; c < C; c++)
         if (col[c]) row = row | keys[c*R +: R];
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int code, input bit rel, input bit chkp, input bit p);
      ev_t e;
      e.code = 4'(code);
      e.rel  = rel;
      e.chkp = chkp;
      e.p    = p;
      q.push_back(e);
   endtask

   // Monitor: every accepted event must match the head of the queue
   always @(negedge clk) begin
      ev_t e;
      if (!rst && key_valid && key_ready) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got code %0d rel %0d, expected none",
                     key_code, key_release);
         end else begin
            e = q.pop_front();
            chk("ev_code", key_code, e.code);
            chk("ev_release", key_release, e.rel);
            if (e.chkp) chk("ev_pressed", pressed, e.p);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int lat;
      key_ready = 1'b1;
      @(negedge clk);
      chk("reset_col", col, 1);
      chk("reset_outputs",
          {key_valid, pressed, multi, overrun, key_release, key_code}, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: idle scan sequence
      for (int k = 0; k < 2*F; k++) begin
         chk("idle_col", col, 1 << ((k / S) % C));
         chk("idle_outputs", {key_valid, pressed, multi, overrun}, 0);
         @(negedge clk);
      end

      // 2: press key 6 (col 1, row 2)
      tick(1);
      keys = 16'h0040;
      push(6, 1'b0, 1'b1, 1'b1);
      lat = 0;
      while (!pressed && lat < 300) begin
         tick(1);
         lat++;
      end
      chk("press6_seen", pressed, 1);
      chk("press6_valid_with_pressed", key_valid, 1);
      chk("press6_latency_in_range", int'(lat >= 64 && lat <= 140), 1);
      tick(2*F);
      chk("press6_single_pulse", key_valid, 0);

      // 3: release key 6
      keys = '0;
      push(6, 1'b1, 1'b1, 1'b0);
      lat = 0;
      while (pressed && lat < 300) begin
         tick(1);
         lat++;
      end
      chk("release6_pressed_fell", pressed, 0);
      chk("release6_valid_same_cycle", key_valid, 1);
      chk("release6_flag", key_release, 1);
      tick(2*F);

      // 4: bounce on row 0, then a steady key 0
      for (int i = 0; i < 16; i++) begin
         bounce = ~bounce;
         tick(20);
      end
      chk("bounce_no_press", pressed, 0);
      chk("bounce_no_multi", multi, 0);
      bounce = 1'b0;
      keys = 16'h0001;
      push(0, 1'b0, 1'b1, 1'b1);
      tick(5*F);
      chk("key0_pressed", pressed, 1);
      keys = '0;
      push(0, 1'b1, 1'b1, 1'b0);
      tick(5*F);

      // 5: multi-key lockout
      keys = 16'h4002;
      tick(5*F);
      chk("multi_set", multi, 1);
      chk("multi_pressed", pressed, 1);
      keys = 16'h0002;
      tick(5*F);
      chk("lockout_multi_clear", multi, 0);
      chk("lockout_still_pressed", pressed, 1);
      keys = '0;
      tick(5*F);
      chk("lockout_all_released", pressed, 0);
      keys = 16'h0008;
      push(3, 1'b0, 1'b1, 1'b1);
      tick(5*F);
      chk("key3_pressed", pressed, 1);
      keys = '0;
      push(3, 1'b1, 1'b1, 1'b0);
      tick(5*F);
      chk("no_overrun_with_ready", overrun, 0);

      // 6: stalled consumer and overrun
      key_ready = 1'b0;
      keys = 16'h0020;
      push(5, 1'b0, 1'b0, 1'b0);
      tick(5*F);
      chk("held_valid", key_valid, 1);
      chk("held_code", key_code, 5);
      chk("held_release", key_release, 0);
      chk("held_no_overrun", overrun, 0);
      keys = '0;
      tick(5*F);
      chk("overrun_set", overrun, 1);
      chk("held_valid_after_drop", key_valid, 1);
      chk("held_code_after_drop", key_code, 5);
      chk("held_release_after_drop", key_release, 0);
      chk("pressed_after_release", pressed, 0);
      key_ready = 1'b1;
      tick(3);
      chk("valid_after_handshake", key_valid, 0);
      chk("overrun_sticky", overrun, 1);
      chk("queue_drained", q.size(), 0);

      // Reset while an event is pending
      key_ready = 1'b0;
      keys = 16'h0200;
      push(9, 1'b0, 1'b0, 1'b0);
      tick(5*F);
      chk("key9_pending", key_valid, 1);
      tick(3);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", key_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_pressed", pressed, 0);
      chk("rst_col", col, 1);
      q.delete();
      keys = '0;
      tick(2);
      rst = 1'b0;
      key_ready = 1'b1;
      tick(5*F);
      chk("post_rst_idle", {key_valid, pressed, multi, overrun}, 0);
      chk("final_queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
